// File: rtl/axi_led_slave.sv
// AXI4-Lite slave driving board LEDs with an inactivity timeout.
// Registers: LED, WCOUNT, TIMEOUT, STATUS at word offsets 0..3.
module axi_led_slave #(
  parameter int unsigned LED_WIDTH     = 4,
  parameter logic [31:0] RESET_TIMEOUT = 32'd0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          S_AXI_AWADDR,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [2:0]           S_AXI_AWPROT,
  input  logic [31:0]          S_AXI_WDATA,
  input  logic [3:0]           S_AXI_WSTRB,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  output logic [1:0]           S_AXI_BRESP,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  input  logic [31:0]          S_AXI_ARADDR,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  input  logic [2:0]           S_AXI_ARPROT,
  output logic [31:0]          S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic [LED_WIDTH-1:0] leds
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                 rdy_en;
  logic                 aw_held, w_held;
  logic [1:0]           aw_addr_q;
  logic [31:0]          w_data_q;
  logic [3:0]           w_strb_q;
  logic [LED_WIDTH-1:0] led_q;
  logic [31:0]          wcount_q, timeout_q, idle_q;
  logic [31:0]          rdata_q;
  logic                 stale_q, rerr_q;
  logic [1:0]           bresp_q;

  logic [31:0] led_ext, led_new, rd_mux;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_addr;
  logic aw_hs, w_hs, ar_hs, do_wr;
  logic led_wr, to_wr, ro_wr, to_fire;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    led_ext = '0;
    led_ext[LED_WIDTH-1:0] = led_q;
  end

  assign S_AXI_AWREADY = rdy_en && (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = rdy_en && (w_state == W_IDLE) && !w_held;
  assign S_AXI_ARREADY = rdy_en && (r_state == R_IDLE);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A channel counts as present if captured earlier or handshaking now.
  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
  assign do_wr   = (w_state == W_IDLE) && (aw_held || aw_hs)
                && (w_held || w_hs);

  assign led_wr  = do_wr && (wr_addr == 2'd0);
  assign to_wr   = do_wr && (wr_addr == 2'd2);
  assign ro_wr   = do_wr && wr_addr[0];
  assign led_new = merge(led_ext, wr_data, wr_strb);
  assign to_fire = (timeout_q != 32'd0) && !stale_q
                && ((idle_q + 32'd1) == timeout_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      rdy_en  <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      rdy_en  <= 1'b1;
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (do_wr) w_next = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= '0;
      rerr_q    <= 1'b0;
    end else if (do_wr) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= ro_wr ? 2'b10 : 2'b00;
      rerr_q  <= ro_wr;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // An LED write beats a coinciding expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q     <= '0;
      wcount_q  <= '0;
      timeout_q <= RESET_TIMEOUT;
      idle_q    <= '0;
      stale_q   <= 1'b0;
    end else if (led_wr) begin
      led_q    <= led_new[LED_WIDTH-1:0];
      wcount_q <= wcount_q + 32'd1;
      idle_q   <= '0;
      stale_q  <= 1'b0;
    end else if (to_wr) begin
      timeout_q <= merge(timeout_q, wr_data, wr_strb);
      idle_q    <= '0;
    end else if (to_fire) begin
      led_q   <= '0;
      stale_q <= 1'b1;
    end else if ((timeout_q != 32'd0) && !stale_q) begin
      idle_q <= idle_q + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (S_AXI_ARADDR[3:2])
      2'd0: rd_mux = led_ext;
      2'd1: rd_mux = wcount_q;
      2'd2: rd_mux = timeout_q;
      2'd3: rd_mux = {30'd0, rerr_q, stale_q};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else if (ar_hs) rdata_q <= rd_mux;
  end

  assign S_AXI_BVALID = (w_state == W_RESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (r_state == R_DATA);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = 2'b00;
  assign leds         = led_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0],
                       led_new};

endmodule

// File: tb/tb_axi_led_slave.sv
// Scoreboard bench for axi_led_slave: B/R responses checked
// against queued expectations, plus direct output checks.
module tb_axi_led_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  leds;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]  bq[$];
  logic [31:0] rq[$];

  logic [31:0] m_led, m_wcount, m_timeout;
  logic        m_rerr, m_stale;

  axi_led_slave #(.LED_WIDTH(4), .RESET_TIMEOUT(32'd0)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_AWPROT(3'b000),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_ARPROT(3'b000),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [31:0] d,
                                         input logic [3:0]  s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Scoreboard pops on each completed B / R handshake.
  always @(negedge clk) begin
    if (resetn && bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
      else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
    end
    if (resetn && rvalid && rready) begin
      chk("rresp", 32'(rresp), 32'd0);
      if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
      else chk("rdata", rdata, rq.pop_front());
    end
  end

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  s);
    bit aw_d, w_d, done;
    int t;
    bq.push_back(a[2] ? 2'b10 : 2'b00);
    m_rerr = a[2];
    if (a[3:2] == 2'd0) begin
      m_led    = bmerge(m_led, d, s) & 32'hF;
      m_wcount = m_wcount + 1;
      m_stale  = 1'b0;
    end else if (a[3:2] == 2'd2) begin
      m_timeout = bmerge(m_timeout, d, s);
    end
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_d = 0; w_d = 0; t = 0;
    while (!(aw_d && w_d) && t < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready) w_d = 1;
      @(posedge clk); #1;
      if (aw_d) awvalid = 1'b0;
      if (w_d) wvalid = 1'b0;
      t++;
    end
    chk("wr_handshake", {30'd0, aw_d, w_d}, 32'd3);
    done = 0; t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      if (t == 0) chk("b_latency", 32'(bvalid), 32'd1);
      if (bvalid && bready) done = 1;
      @(posedge clk); #1;
      t++;
    end
    chk("b_done", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return m_led;
      2'd1:    return m_wcount;
      2'd2:    return m_timeout;
      default: return {30'd0, m_rerr, m_stale};
    endcase
  endfunction

  task automatic rd(input logic [31:0] a);
    bit ar_d, done;
    int t;
    rq.push_back(model_rd(a));
    araddr = a; arvalid = 1'b1;
    ar_d = 0; t = 0;
    while (!ar_d && t < 20) begin
      @(negedge clk);
      if (arready) ar_d = 1;
      @(posedge clk); #1;
      if (ar_d) arvalid = 1'b0;
      t++;
    end
    chk("ar_handshake", 32'(ar_d), 32'd1);
    done = 0; t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      if (t == 0) chk("r_latency", 32'(rvalid), 32'd1);
      if (rvalid && rready) done = 1;
      @(posedge clk); #1;
      t++;
    end
    chk("r_done", 32'(done), 32'd1);
  endtask

  task automatic model_reset();
    m_led = 0; m_wcount = 0; m_timeout = 0;
    m_rerr = 0; m_stale = 0;
  endtask

  initial begin
    resetn = 1'b0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1'b1; rready = 1'b1;
    model_reset();

    // Reset state and ready rise
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 32'(awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("awready_up", 32'(awready), 32'd1);
    chk("wready_up", 32'(wready), 32'd1);
    chk("arready_up", 32'(arready), 32'd1);
    @(posedge clk); #1;

    // Simultaneous AW/W write
    wr(32'h0, 32'h5, 4'hF);
    chk("leds_5", 32'(leds), 32'h5);
    rd(32'h4);

    // W ahead of AW, BREADY held low
    bq.push_back(2'b00);
    m_led = 32'hA; m_wcount++; m_rerr = 0;
    bready = 1'b0;
    wdata = 32'hA; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("w_early_ready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no_b_early", 32'(bvalid), 32'd0);
      chk("wready_held", 32'(wready), 32'd0);
      @(posedge clk); #1;
    end
    awaddr = 32'h0; awvalid = 1'b1;
    @(negedge clk);
    chk("no_b_pre_aw", 32'(bvalid), 32'd0);
    chk("aw_late_ready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("b_hold", 32'(bvalid), 32'd1);
      chk("aw_blocked", 32'(awready), 32'd0);
      chk("w_blocked", 32'(wready), 32'd0);
      chk("leds_A", 32'(leds), 32'hA);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_release", 32'(bvalid), 32'd0);
    chk("aw_reopen", 32'(awready), 32'd1);
    chk("w_reopen", 32'(wready), 32'd1);
    @(posedge clk); #1;

    // Timeout of 10 cycles after an LED write
    wr(32'h8, 32'd10, 4'hF);
    wr(32'h0, 32'h3, 4'hF);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk(k < 10 ? "leds_pre_to" : "leds_to",
          32'(leds), k < 10 ? 32'h3 : 32'h0);
      @(posedge clk); #1;
    end
    m_led = 0; m_stale = 1'b1;
    rd(32'hC);
    wr(32'h0, 32'h2, 4'hF);
    chk("leds_after_to", 32'(leds), 32'h2);
    rd(32'hC);
    wr(32'h8, 32'd0, 4'hF);

    // Writes to read-only registers
    wr(32'h4, 32'h1234, 4'hF);
    rd(32'h4);
    rd(32'hC);
    wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0, 32'h6, 4'hF);
    rd(32'hC);

    // Upper address bits, byte strobes, empty strobe
    wr(32'hABCD_0000, 32'h0000_000C, 4'h1);
    chk("leds_C", 32'(leds), 32'hC);
    wr(32'h0, 32'hF, 4'h0);
    chk("leds_strb0", 32'(leds), 32'hC);
    rd(32'h4);
    wr(32'h8, 32'h1234_5678, 4'b0101);

    // Delayed RREADY keeps RDATA stable
    rq.push_back(model_rd(32'h8));
    rready = 1'b0;
    araddr = 32'h8; arvalid = 1'b1;
    @(negedge clk);
    chk("ar_ready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("r_hold", 32'(rvalid), 32'd1);
      chk("r_stable", rdata, 32'h0034_0078);
      chk("ar_blocked", 32'(arready), 32'd0);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while BVALID is high
    bready = 1'b0;
    awaddr = 32'h0; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
    chk("pre_rst_leds", 32'(leds), 32'h9);
    #2 resetn = 1'b0;
    #1;
    chk("async_bvalid", 32'(bvalid), 32'd0);
    chk("async_leds", 32'(leds), 32'd0);
    chk("async_awready", 32'(awready), 32'd0);
    bready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_no_rdy", 32'(awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready", 32'(wready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    rd(32'h0);
    rd(32'h4);
    rd(32'h8);
    rd(32'hC);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(bq.size() + rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_led_slave.md
# axi_led_slave

AXI4-Lite slave that terminates the system interconnect writes issued by the LED traffic generator and drives the board LEDs. It holds a small four-register map: LED value, accepted-write count, inactivity timeout, and status. The timeout blanks the LEDs when the upstream writer goes quiet, for example when the link drops. The block sits on an interconnect master port at the generator's target address.

## Interface
- LED_WIDTH, 4: number of LED outputs, 1..32.
- RESET_TIMEOUT, 0: reset value of the TIMEOUT register, in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low. This is fixed.
- S_AXI_AWADDR  in  32  write address; only bits [3:2] are decoded.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake.
- S_AXI_BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake.
- S_AXI_ARADDR  in  32  read address; only bits [3:2] are decoded.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake.
- leds  out  LED_WIDTH  registered LED drive.

## Operation
Register map (offset = addr[3:2]*4; upper address bits are ignored):
- 0x0 LED, RW: bits [LED_WIDTH-1:0]; unused bits read 0.
- 0x4 WCOUNT, RO: count of write handshakes to LED; wraps 0xFFFF_FFFF -> 0.
- 0x8 TIMEOUT, RW: 32-bit timeout in clk cycles.
- 0xC STATUS, RO: bit0 stale (timeout fired), bit1 rerr (last write targeted a RO register); other bits 0.

Write strobes:
- WSTRB applies per byte lane to LED and TIMEOUT.
- WSTRB=4'b0000 returns OKAY and leaves data unchanged, but still counts as an LED write (increments WCOUNT, restarts the timer).

Writes to RO registers (WCOUNT, STATUS):
- return SLVERR, change no data, set rerr.
- Any OKAY write clears rerr.

Write FSM (states W_IDLE, W_RESP):
- W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W are captured independently, in either order or in the same cycle.
- When both are held, the register update occurs on the next edge, BVALID rises on that edge, and the FSM enters W_RESP. AWREADY and WREADY are 0 throughout W_RESP.
- W_RESP: BVALID and BRESP hold until BREADY=1; then return to W_IDLE with both READYs at 1 on the following cycle.

Read FSM (states R_IDLE, R_DATA):
- R_IDLE: ARREADY=1. On handshake, RDATA is latched and RVALID=1 on the next edge; ARREADY=0.
- R_DATA: RDATA and RVALID hold until RREADY=1; then return to R_IDLE.
- Reads and writes are fully independent. A read in the same cycle as a write to the same register returns the pre-write value.

Timeout:
- A 32-bit idle counter increments every cycle while TIMEOUT!=0 and stale=0.
- An LED write or a TIMEOUT write clears the counter.
- When counter+1 == TIMEOUT: leds <= 0, LED register <= 0, stale <= 1, and the counter holds.
- An LED write clears stale. If the expiry and an LED write land on the same edge, the write wins: new value, stale=0, counter=0.
- TIMEOUT=0 disables the timeout; stale keeps its value.

## Timing
- In reset: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, leds=0, LED=0, WCOUNT=0, TIMEOUT=RESET_TIMEOUT, STATUS=0, idle counter=0.
- AWREADY, WREADY and ARREADY rise on the first clk edge after resetn deasserts.
- Write latency: BVALID rises one cycle after the later of the AW and W handshakes. leds changes on the same edge.
- Read latency: RVALID rises one cycle after the AR handshake.
- Back-to-back throughput: one write per 2 cycles and one read per 2 cycles when BREADY and RREADY are held at 1.
- resetn asserted mid-transaction aborts it immediately with no response. Any partially captured AW or W is discarded.

## Test plan
- Reset with RESET_TIMEOUT=0, write 0x5 to 0x0 with AW and W in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00; leds=4'h5; reading 0x4 returns 1.
- W presented 3 cycles before AW, 0x0 data 0xA, with BREADY held 0 for 4 cycles -> no handshake before AW; BVALID holds 4 cycles; leds=4'hA; AWREADY and WREADY stay 0 until BREADY.
- Write 0x8=10, then LED=0x3, then idle -> leds=0 and STATUS=0x1 exactly 10 cycles after the LED write edge; a new LED write of 0x2 -> leds=2, STATUS=0.
- Write to 0x4 -> BRESP=10, WCOUNT unchanged, STATUS bit1=1; the next LED write gives OKAY and clears bit1.
- LED write with WSTRB=0000 -> OKAY, leds unchanged, WCOUNT increments; a read of 0x8 with RREADY delayed 5 cycles -> RDATA stable for all 5 cycles.
- Assert resetn=0 while BVALID=1 -> BVALID=0 and leds=0 immediately (asynchronous); READYs return 1 the first edge after release.
